// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared definitions for the single-outstanding memory responder.
//   state_e            2-bit FSM encoding (IDLE, BUSY, RESP), also exported for debug
//   CNT_W              width of the latency down-counter (LATENCY legal range 1..15)
//   DEFAULT_BASE_ADDR  byte address of word 0 unless overridden
//   apply_wmask()      byte-lane merge used by the storage array
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int CNT_W = 4;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  // Replace only the byte lanes whose mask bit is set.
  function automatic logic [31:0] apply_wmask(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  wmask);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wmask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// mem_array: word-addressed storage with byte-masked synchronous write and
// asynchronous read. Contents are deliberately not reset.
//   clk      clock
//   we_i     write enable (one word per edge)
//   addr_i   word index, shared by read and write
//   wdata_i  write data
//   wmask_i  byte-lane enables for the write
//   rdata_o  combinational read of the word at addr_i
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    wmask_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= apply_wmask(mem_q[addr_i], wdata_i, wmask_i);
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory target with a fixed response latency.
//   clk, rst                 clock; asynchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_addr/req_wen         byte address, 1 = write
//   req_wdata/req_wmask      write data and byte-lane enables
//   resp_valid/resp_ready    response handshake
//   resp_rdata/resp_err      read data (0 for writes/errors), error flag
//   dbg_state                current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid && ready. The
// initiator keeps a request stable until it is accepted; the responder keeps
// resp_valid/resp_rdata/resp_err stable until resp_ready is seen high on an edge.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output state_e      dbg_state
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Byte span of the storage, held in 34 bits so BASE_ADDR near 2^32 cannot wrap.
  localparam logic [33:0] SPAN = 34'(DEPTH_WORDS) * 34'd4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic               wen_q, wen_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wmask_q, wmask_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [31:0]        offset;
  logic               addr_err;
  logic [AW-1:0]      word_idx;
  logic               mem_we;
  logic [31:0]        mem_rdata;

  // Offset is only meaningful when addr >= BASE_ADDR; the lower-bound test
  // guards the wrapped case so the upper-bound test never sees it.
  assign offset   = addr_q - BASE_ADDR;
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) ||
                    ({2'b00, offset} >= SPAN);
  assign word_idx = AW'(offset >> 2);

  mem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (word_idx),
    .wdata_i (wdata_q),
    .wmask_i (wmask_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wen_d   = req_wen;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          cnt_d   = CNT_LOAD;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          // The access executes on this edge; an error leaves storage untouched.
          mem_we  = wen_q && !addr_err;
          err_d   = addr_err;
          rdata_d = (wen_q || addr_err) ? 32'h0 : mem_rdata;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_err   = resp_valid && err_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words of storage.
REQ-002 Parameter LATENCY, default 2: clock edges from request acceptance to response valid; legal range 1..15.
REQ-003 Parameter BASE_ADDR, default 32'h80000000: byte address of word 0.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wen  input  1  1 = write, 0 = read.
REQ-010 req_wdata  input  32  write data.
REQ-011 req_wmask  input  4  byte-lane enables; bit i enables bits 8i+7:8i.
REQ-012 resp_valid  output  1  response is present.
REQ-013 resp_ready  input  1  initiator consumes the response.
REQ-014 resp_rdata  output  32  read data; 0 for writes and errors.
REQ-015 resp_err  output  1  access was misaligned or out of range.

Function
REQ-016 The block SHALL implement FSM states IDLE, BUSY and RESP, with at most one request outstanding.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-018 On acceptance, the block SHALL latch addr, wen, wdata and wmask, load the counter with LATENCY-1, and move to BUSY.
REQ-019 In BUSY, the counter SHALL decrement each edge; on the edge where it is 0, the access executes and the state moves to RESP.
REQ-020 As a result, resp_valid SHALL rise exactly LATENCY edges after the accepting edge.
REQ-021 A read SHALL return the stored word at (addr-BASE_ADDR)>>2.
REQ-022 A write SHALL update only the enabled byte lanes; wmask=4'b0000 is a legal no-op write that still responds.
REQ-023 The request is an error if addr[1:0]!=0, addr<BASE_ADDR, or addr>=BASE_ADDR+4*DEPTH_WORDS.
REQ-024 For an error request: resp_err=1, resp_rdata=0, and storage is unmodified.
REQ-025 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until an edge with resp_ready=1, then go to IDLE.
REQ-026 resp_valid SHALL be 0 in IDLE and BUSY, and resp_rdata/resp_err SHALL be 0 outside RESP.
REQ-027 A request presented while not in IDLE SHALL be ignored and not stored; the initiator holds it until req_ready.
REQ-028 Back-to-back operation: with resp_ready=1 in RESP, the block reaches IDLE on the next edge, so the next acceptance is possible one cycle later.
REQ-029 Read-after-write to the same address SHALL return the newly written bytes.
REQ-030 Address arithmetic SHALL be 32-bit unsigned; the range check SHALL not wrap for BASE_ADDR near 2^32.

Reset
REQ-031 While rst=1, state SHALL be IDLE, counter 0, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0.
REQ-032 Asserting rst in BUSY or RESP SHALL abort the transaction; a write not yet executed SHALL not occur.
REQ-033 Storage contents SHALL not be cleared by reset.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding (2-bit), the LATENCY counter width (4), and the default BASE_ADDR.
REQ-035 Storage SHALL be a sub-module mem_array: synchronous write with byte mask, asynchronous word read, no reset.

Verification
REQ-036 With LATENCY=2, write 32'hDEADBEEF to 32'h80000010 with mask 4'hF, then read it back -> write response has resp_err=0 and rdata=0; read response arrives 2 edges after acceptance with rdata=32'hDEADBEEF.
REQ-037 With 32'h11223344 at 32'h80000000, write 32'hAABBCCDD with mask 4'b0101, then read -> rdata=32'h11BB33DD.
REQ-038 Read 32'h80000002, then read 32'h7FFFFFFC, then read 32'h80001000 (DEPTH_WORDS=1024) -> each response has resp_err=1 and rdata=0, and no storage changes.
REQ-039 Hold resp_ready=0 for 5 cycles in RESP while driving req_valid=1 -> resp outputs stay stable, req_ready=0, and the second request is accepted only after the response handshake.
REQ-040 Assert rst one cycle after accepting a write of 32'h0 to 32'h80000020 (LATENCY=3), holding the old value 32'h55 -> outputs return to reset values and a subsequent read returns 32'h55.
REQ-041 With LATENCY=1 and resp_ready tied to 1, issue 8 consecutive reads -> one response every 3 cycles.
